// File: rtl/prt_multislot.sv
// Packet reference table with NUM_SLOTS slots of up to DEPTH words each.
// A writer fills one slot while a reader drains another.
// Write side: start (allocate lowest FREE slot), write (append word), finish (commit), abort (discard).
// Read side: start read (by slot), read ({last, data} stream), invalidate (release a VALID/READING slot).
// Status: is_prt_slot_free, free_slot_count, start_writing_prt_entry (next slot to be allocated).
// Every RDY and data output is combinational from registered state plus method arguments.
module prt_multislot #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 1536,
  parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS),
  parameter int unsigned LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           EN_start_writing_prt_entry,
  output logic [SLOT_W-1:0]              start_writing_prt_entry,
  output logic                           RDY_start_writing_prt_entry,
  input  logic [DATA_W-1:0]              write_prt_entry_data,
  input  logic                           EN_write_prt_entry,
  output logic                           RDY_write_prt_entry,
  input  logic                           EN_finish_writing_prt_entry,
  output logic                           RDY_finish_writing_prt_entry,
  input  logic                           EN_abort_writing_prt_entry,
  output logic                           RDY_abort_writing_prt_entry,
  input  logic [SLOT_W-1:0]              invalidate_prt_entry_slot,
  input  logic                           EN_invalidate_prt_entry,
  output logic                           RDY_invalidate_prt_entry,
  input  logic [SLOT_W-1:0]              start_reading_prt_entry_slot,
  input  logic                           EN_start_reading_prt_entry,
  output logic                           RDY_start_reading_prt_entry,
  input  logic                           EN_read_prt_entry,
  output logic [DATA_W:0]                read_prt_entry,
  output logic                           RDY_read_prt_entry,
  output logic                           is_prt_slot_free,
  output logic                           RDY_is_prt_slot_free,
  output logic [$clog2(NUM_SLOTS+1)-1:0] free_slot_count
);

  localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_FREE, S_WRITING, S_VALID, S_READING} slot_st_e;
  typedef enum logic {W_IDLE, W_ACTIVE} w_state_e;
  typedef enum logic {R_IDLE, R_ACTIVE} r_state_e;

  slot_st_e          slot_st_q  [NUM_SLOTS];
  slot_st_e          slot_st_d  [NUM_SLOTS];
  logic [LEN_W-1:0]  slot_len_q [NUM_SLOTS];
  logic [LEN_W-1:0]  slot_len_d [NUM_SLOTS];
  logic [DATA_W-1:0] mem_q      [NUM_SLOTS][DEPTH];

  w_state_e          w_state_q, w_state_d;
  logic [SLOT_W-1:0] w_slot_q, w_slot_d;
  logic [LEN_W-1:0]  w_cnt_q, w_cnt_d;
  r_state_e          r_state_q, r_state_d;
  logic [SLOT_W-1:0] r_slot_q, r_slot_d;
  logic [LEN_W-1:0]  r_ptr_q, r_ptr_d;

  logic              any_free;
  logic [SLOT_W-1:0] alloc_slot;
  logic [CNT_W-1:0]  free_cnt;
  logic              rd_last;
  logic              start_wr_fire, wr_fire, fin_fire, abort_fire;
  logic              rd_start_fire, rd_fire, inv_fire;
  logic              inv_hits_rd_start;

  // State register for slot table and both FSMs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_st_q[i]  <= S_FREE;
        slot_len_q[i] <= '0;
      end
      w_state_q <= W_IDLE;
      w_slot_q  <= '0;
      w_cnt_q   <= '0;
      r_state_q <= R_IDLE;
      r_slot_q  <= '0;
      r_ptr_q   <= '0;
    end else begin
      slot_st_q  <= slot_st_d;
      slot_len_q <= slot_len_d;
      w_state_q  <= w_state_d;
      w_slot_q   <= w_slot_d;
      w_cnt_q    <= w_cnt_d;
      r_state_q  <= r_state_d;
      r_slot_q   <= r_slot_d;
      r_ptr_q    <= r_ptr_d;
    end
  end

  // Packet storage; contents survive reset, lengths decide what is visible
  always_ff @(posedge CLK) begin
    if (wr_fire) mem_q[w_slot_q][w_cnt_q[IDX_W-1:0]] <= write_prt_entry_data;
  end

  // Free-slot priority encoder (descending scan leaves the lowest index) and count
  always_comb begin
    any_free   = 1'b0;
    alloc_slot = '0;
    free_cnt   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_st_q[i] == S_FREE) begin
        any_free   = 1'b1;
        alloc_slot = SLOT_W'(i);
        free_cnt   = free_cnt + CNT_W'(1);
      end
    end
  end

  // Writer outputs
  always_comb begin
    start_writing_prt_entry      = alloc_slot;
    RDY_start_writing_prt_entry  = (w_state_q == W_IDLE) && any_free;
    RDY_write_prt_entry          = (w_state_q == W_ACTIVE) && (w_cnt_q < LEN_W'(DEPTH));
    RDY_finish_writing_prt_entry = (w_state_q == W_ACTIVE) && (w_cnt_q != '0);
    RDY_abort_writing_prt_entry  = (w_state_q == W_ACTIVE);
    is_prt_slot_free             = any_free;
    RDY_is_prt_slot_free         = 1'b1;
    free_slot_count              = free_cnt;
  end

  // Reader and invalidate outputs
  always_comb begin
    rd_last                     = (r_ptr_q == slot_len_q[r_slot_q] - LEN_W'(1));
    RDY_read_prt_entry          = (r_state_q == R_ACTIVE);
    RDY_start_reading_prt_entry = (r_state_q == R_IDLE) &&
                                  (slot_st_q[start_reading_prt_entry_slot] == S_VALID);
    RDY_invalidate_prt_entry    = (slot_st_q[invalidate_prt_entry_slot] == S_VALID) ||
                                  (slot_st_q[invalidate_prt_entry_slot] == S_READING);
    read_prt_entry              = '0;
    if (r_state_q == R_ACTIVE) read_prt_entry = {rd_last, mem_q[r_slot_q][r_ptr_q[IDX_W-1:0]]};
  end

  assign start_wr_fire     = EN_start_writing_prt_entry & RDY_start_writing_prt_entry;
  assign wr_fire           = EN_write_prt_entry & RDY_write_prt_entry;
  assign fin_fire          = EN_finish_writing_prt_entry & RDY_finish_writing_prt_entry;
  assign abort_fire        = EN_abort_writing_prt_entry & RDY_abort_writing_prt_entry;
  assign rd_start_fire     = EN_start_reading_prt_entry & RDY_start_reading_prt_entry;
  assign rd_fire           = EN_read_prt_entry & RDY_read_prt_entry;
  assign inv_fire          = EN_invalidate_prt_entry & RDY_invalidate_prt_entry;
  assign inv_hits_rd_start = inv_fire && (invalidate_prt_entry_slot == start_reading_prt_entry_slot);

  // Writer next state
  always_comb begin
    w_state_d = w_state_q;
    w_slot_d  = w_slot_q;
    w_cnt_d   = w_cnt_q;
    case (w_state_q)
      W_IDLE: begin
        if (start_wr_fire) begin
          w_state_d = W_ACTIVE;
          w_slot_d  = alloc_slot;
          w_cnt_d   = '0;
        end
      end
      W_ACTIVE: begin
        if (fin_fire || abort_fire) w_state_d = W_IDLE;
        else if (wr_fire)          w_cnt_d   = w_cnt_q + LEN_W'(1);
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Reader next state; an invalidate of the slot being read (or started) wins
  always_comb begin
    r_state_d = r_state_q;
    r_slot_d  = r_slot_q;
    r_ptr_d   = r_ptr_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_start_fire && !inv_hits_rd_start) begin
          r_state_d = R_ACTIVE;
          r_slot_d  = start_reading_prt_entry_slot;
          r_ptr_d   = '0;
        end
      end
      R_ACTIVE: begin
        if (inv_fire && (invalidate_prt_entry_slot == r_slot_q)) r_state_d = R_IDLE;
        else if (rd_fire && rd_last)                              r_state_d = R_IDLE;
        else if (rd_fire)                                         r_ptr_d   = r_ptr_q + LEN_W'(1);
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Slot table next state; invalidate is applied last so it overrides read updates
  always_comb begin
    slot_st_d  = slot_st_q;
    slot_len_d = slot_len_q;
    if (start_wr_fire) slot_st_d[alloc_slot] = S_WRITING;
    if (fin_fire) begin
      slot_st_d[w_slot_q]  = S_VALID;
      slot_len_d[w_slot_q] = w_cnt_q;
    end
    if (abort_fire)         slot_st_d[w_slot_q] = S_FREE;
    if (rd_start_fire)      slot_st_d[start_reading_prt_entry_slot] = S_READING;
    if (rd_fire && rd_last) slot_st_d[r_slot_q] = S_VALID;
    if (inv_fire)           slot_st_d[invalidate_prt_entry_slot] = S_FREE;
  end

  // Write, finish and abort are mutually exclusive requests
  a_wr_ops_exclusive: assert property (@(posedge CLK) disable iff (RST)
    $onehot0({EN_write_prt_entry, EN_finish_writing_prt_entry, EN_abort_writing_prt_entry}));

endmodule

// File: tb/tb_prt_multislot.sv
// Self-checking bench for prt_multislot: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based packet table model.
module tb_prt_multislot;

  localparam int NS    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1536;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN_start_writing_prt_entry;
  logic [1:0]    start_writing_prt_entry;
  logic          RDY_start_writing_prt_entry;
  logic [DW-1:0] write_prt_entry_data;
  logic          EN_write_prt_entry;
  logic          RDY_write_prt_entry;
  logic          EN_finish_writing_prt_entry;
  logic          RDY_finish_writing_prt_entry;
  logic          EN_abort_writing_prt_entry;
  logic          RDY_abort_writing_prt_entry;
  logic [1:0]    invalidate_prt_entry_slot;
  logic          EN_invalidate_prt_entry;
  logic          RDY_invalidate_prt_entry;
  logic [1:0]    start_reading_prt_entry_slot;
  logic          EN_start_reading_prt_entry;
  logic          RDY_start_reading_prt_entry;
  logic          EN_read_prt_entry;
  logic [DW:0]   read_prt_entry;
  logic          RDY_read_prt_entry;
  logic          is_prt_slot_free;
  logic          RDY_is_prt_slot_free;
  logic [2:0]    free_slot_count;

  prt_multislot #(.NUM_SLOTS(NS), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK                          (CLK),
    .RST                          (RST),
    .EN_start_writing_prt_entry   (EN_start_writing_prt_entry),
    .start_writing_prt_entry      (start_writing_prt_entry),
    .RDY_start_writing_prt_entry  (RDY_start_writing_prt_entry),
    .write_prt_entry_data         (write_prt_entry_data),
    .EN_write_prt_entry           (EN_write_prt_entry),
    .RDY_write_prt_entry          (RDY_write_prt_entry),
    .EN_finish_writing_prt_entry  (EN_finish_writing_prt_entry),
    .RDY_finish_writing_prt_entry (RDY_finish_writing_prt_entry),
    .EN_abort_writing_prt_entry   (EN_abort_writing_prt_entry),
    .RDY_abort_writing_prt_entry  (RDY_abort_writing_prt_entry),
    .invalidate_prt_entry_slot    (invalidate_prt_entry_slot),
    .EN_invalidate_prt_entry      (EN_invalidate_prt_entry),
    .RDY_invalidate_prt_entry     (RDY_invalidate_prt_entry),
    .start_reading_prt_entry_slot (start_reading_prt_entry_slot),
    .EN_start_reading_prt_entry   (EN_start_reading_prt_entry),
    .RDY_start_reading_prt_entry  (RDY_start_reading_prt_entry),
    .EN_read_prt_entry            (EN_read_prt_entry),
    .read_prt_entry               (read_prt_entry),
    .RDY_read_prt_entry           (RDY_read_prt_entry),
    .is_prt_slot_free             (is_prt_slot_free),
    .RDY_is_prt_slot_free         (RDY_is_prt_slot_free),
    .free_slot_count              (free_slot_count)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per-slot status (0 free, 1 writing, 2 valid, 3 reading) and packet contents
  int            m_st [NS];
  logic [DW-1:0] m_data [NS][$];
  bit            m_wact, m_ract;
  int            m_wslot, m_rslot, m_ridx;

  // Expected outputs derived from the model
  int          e_alloc, e_cnt;
  bit          e_any, e_rdy_sw, e_rdy_w, e_rdy_f, e_rdy_a, e_rdy_inv, e_rdy_sr, e_rdy_r;
  logic [DW:0] e_read;

  logic [DW:0] t1_exp [3] = '{9'h0A1, 9'h0A2, 9'h1A3};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NS; i++) m_st[i] = 0;
    m_wact = 0; m_ract = 0; m_wslot = 0; m_rslot = 0; m_ridx = 0;
  endtask

  task automatic model_outputs();
    e_alloc = 0; e_cnt = 0; e_any = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_st[i] == 0) begin
        if (!e_any) e_alloc = i;
        e_any = 1;
        e_cnt++;
      end
    end
    e_rdy_sw  = !m_wact && e_any;
    e_rdy_w   = m_wact && (m_data[m_wslot].size() < DEPTH);
    e_rdy_f   = m_wact && (m_data[m_wslot].size() >= 1);
    e_rdy_a   = m_wact;
    e_rdy_inv = (m_st[invalidate_prt_entry_slot] >= 2);
    e_rdy_sr  = !m_ract && (m_st[start_reading_prt_entry_slot] == 2);
    e_rdy_r   = m_ract;
    e_read    = '0;
    if (m_ract)
      e_read = {m_ridx == m_data[m_rslot].size() - 1, m_data[m_rslot][m_ridx]};
  endtask

  task automatic check_all();
    model_outputs();
    chk("alloc_slot",   64'(start_writing_prt_entry),      64'(e_alloc));
    chk("rdy_start_wr", 64'(RDY_start_writing_prt_entry),  64'(e_rdy_sw));
    chk("rdy_write",    64'(RDY_write_prt_entry),          64'(e_rdy_w));
    chk("rdy_finish",   64'(RDY_finish_writing_prt_entry), 64'(e_rdy_f));
    chk("rdy_abort",    64'(RDY_abort_writing_prt_entry),  64'(e_rdy_a));
    chk("rdy_inval",    64'(RDY_invalidate_prt_entry),     64'(e_rdy_inv));
    chk("rdy_start_rd", 64'(RDY_start_reading_prt_entry),  64'(e_rdy_sr));
    chk("rdy_read",     64'(RDY_read_prt_entry),           64'(e_rdy_r));
    chk("read_entry",   64'(read_prt_entry),               64'(e_read));
    chk("slot_free",    64'(is_prt_slot_free),             64'(e_any));
    chk("rdy_is_free",  64'(RDY_is_prt_slot_free),         64'd1);
    chk("free_count",   64'(free_slot_count),              64'(e_cnt));
  endtask

  // Apply the accepted methods of this cycle to the model
  task automatic model_step();
    bit f_sw, f_w, f_f, f_a, f_sr, f_r, f_inv;
    int iinv, isr;
    if (RST) begin m_reset(); return; end
    model_outputs();
    iinv  = int'(invalidate_prt_entry_slot);
    isr   = int'(start_reading_prt_entry_slot);
    f_inv = EN_invalidate_prt_entry && e_rdy_inv;
    f_sw  = EN_start_writing_prt_entry && e_rdy_sw;
    f_w   = EN_write_prt_entry && e_rdy_w;
    f_f   = EN_finish_writing_prt_entry && e_rdy_f;
    f_a   = EN_abort_writing_prt_entry && e_rdy_a;
    f_sr  = EN_start_reading_prt_entry && e_rdy_sr && !(f_inv && iinv == isr);
    f_r   = EN_read_prt_entry && e_rdy_r && !(f_inv && iinv == m_rslot);
    if (f_sw) begin
      m_st[e_alloc] = 1; m_wslot = e_alloc; m_data[e_alloc].delete(); m_wact = 1;
    end
    if (f_w) m_data[m_wslot].push_back(write_prt_entry_data);
    if (f_f) begin m_st[m_wslot] = 2; m_wact = 0; end
    if (f_a) begin m_st[m_wslot] = 0; m_wact = 0; end
    if (f_sr) begin m_st[isr] = 3; m_ract = 1; m_rslot = isr; m_ridx = 0; end
    if (f_r) begin
      if (m_ridx == m_data[m_rslot].size() - 1) begin m_st[m_rslot] = 2; m_ract = 0; end
      else m_ridx++;
    end
    if (f_inv) begin
      m_st[iinv] = 0;
      if (m_ract && m_rslot == iinv) m_ract = 0;
    end
  endtask

  task automatic idle();
    EN_start_writing_prt_entry   = 1'b0;
    EN_write_prt_entry           = 1'b0;
    EN_finish_writing_prt_entry  = 1'b0;
    EN_abort_writing_prt_entry   = 1'b0;
    EN_invalidate_prt_entry      = 1'b0;
    EN_start_reading_prt_entry   = 1'b0;
    EN_read_prt_entry            = 1'b0;
    write_prt_entry_data         = '0;
    invalidate_prt_entry_slot    = '0;
    start_reading_prt_entry_slot = '0;
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic advance();
    model_step();
    @(negedge CLK);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic write_packet(input int nwords, input int seed);
    idle(); EN_start_writing_prt_entry = 1'b1; tick();
    for (int i = 0; i < nwords; i++) begin
      idle(); EN_write_prt_entry = 1'b1; write_prt_entry_data = 8'(seed + i); tick();
    end
    idle(); EN_finish_writing_prt_entry = 1'b1; tick();
  endtask

  task automatic check_reset_literals(input string tag);
    chk({tag, "_rdy_sw"},  64'(RDY_start_writing_prt_entry),  64'd1);
    chk({tag, "_alloc"},   64'(start_writing_prt_entry),      64'd0);
    chk({tag, "_free"},    64'(is_prt_slot_free),             64'd1);
    chk({tag, "_count"},   64'(free_slot_count),              64'd4);
    chk({tag, "_rdy_is"},  64'(RDY_is_prt_slot_free),         64'd1);
    chk({tag, "_rdy_w"},   64'(RDY_write_prt_entry),          64'd0);
    chk({tag, "_rdy_f"},   64'(RDY_finish_writing_prt_entry), 64'd0);
    chk({tag, "_rdy_a"},   64'(RDY_abort_writing_prt_entry),  64'd0);
    chk({tag, "_rdy_inv"}, 64'(RDY_invalidate_prt_entry),     64'd0);
    chk({tag, "_rdy_sr"},  64'(RDY_start_reading_prt_entry),  64'd0);
    chk({tag, "_rdy_r"},   64'(RDY_read_prt_entry),           64'd0);
    chk({tag, "_read"},    64'(read_prt_entry),               64'd0);
  endtask

  initial begin
    int r;
    m_reset();
    idle();
    @(negedge CLK);
    settle();
    check_reset_literals("reset");
    advance();
    RST = 1'b0;

    // Three-word packet into slot 0, then read it twice
    idle(); EN_start_writing_prt_entry = 1'b1; settle();
    chk("t1_alloc", 64'(start_writing_prt_entry), 64'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      idle(); EN_write_prt_entry = 1'b1; write_prt_entry_data = 8'(8'hA1 + i); tick();
    end
    idle(); EN_finish_writing_prt_entry = 1'b1; tick();
    for (int pass = 0; pass < 2; pass++) begin
      idle(); EN_start_reading_prt_entry = 1'b1; settle();
      chk("t1_rdy_start_rd", 64'(RDY_start_reading_prt_entry), 64'd1);
      advance();
      idle(); EN_read_prt_entry = 1'b1;
      for (int i = 0; i < 3; i++) begin
        settle();
        chk("t1_read_word", 64'(read_prt_entry), 64'(t1_exp[i]));
        advance();
      end
      idle(); settle();
      chk("t1_rdy_read_done", 64'(RDY_read_prt_entry), 64'd0);
      chk("t1_slot0_valid", 64'(RDY_start_reading_prt_entry), 64'd1);
      advance();
    end

    // Fill the remaining slots, then free slot 2
    for (int k = 1; k < NS; k++) write_packet(1, 16 + k);
    idle(); settle();
    chk("t2_no_free", 64'(is_prt_slot_free), 64'd0);
    chk("t2_count0", 64'(free_slot_count), 64'd0);
    chk("t2_rdy_sw0", 64'(RDY_start_writing_prt_entry), 64'd0);
    advance();
    idle(); EN_invalidate_prt_entry = 1'b1; invalidate_prt_entry_slot = 2'd2; tick();
    idle(); settle();
    chk("t2_alloc2", 64'(start_writing_prt_entry), 64'd2);
    chk("t2_rdy_sw1", 64'(RDY_start_writing_prt_entry), 64'd1);
    advance();

    // Full-depth packet in slot 2
    idle(); EN_start_writing_prt_entry = 1'b1; tick();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); EN_write_prt_entry = 1'b1; write_prt_entry_data = 8'(i * 7 + 3); tick();
    end
    idle(); settle();
    chk("t3_rdy_write_full", 64'(RDY_write_prt_entry), 64'd0);
    chk("t3_rdy_finish", 64'(RDY_finish_writing_prt_entry), 64'd1);
    advance();
    idle(); EN_write_prt_entry = 1'b1; write_prt_entry_data = 8'hFF; tick();
    idle(); EN_finish_writing_prt_entry = 1'b1; tick();
    idle(); EN_start_reading_prt_entry = 1'b1; start_reading_prt_entry_slot = 2'd2; tick();
    idle(); EN_read_prt_entry = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      if (i == DEPTH - 1) chk("t3_last_word", 64'(read_prt_entry), 64'({1'b1, 8'((DEPTH - 1) * 7 + 3)}));
      if (i == DEPTH - 2) chk("t3_not_last", 64'(read_prt_entry[DW]), 64'd0);
      advance();
    end

    // Abort a five-word packet
    idle(); EN_invalidate_prt_entry = 1'b1; invalidate_prt_entry_slot = 2'd2; tick();
    write_packet(0, 0);  // start then finish with zero words: finish is not ready, ignored
    for (int i = 0; i < 5; i++) begin
      idle(); EN_write_prt_entry = 1'b1; write_prt_entry_data = 8'(8'h50 + i); tick();
    end
    idle(); EN_abort_writing_prt_entry = 1'b1; tick();
    idle(); start_reading_prt_entry_slot = 2'd2; settle();
    chk("t4_count_restored", 64'(free_slot_count), 64'd1);
    chk("t4_not_readable", 64'(RDY_start_reading_prt_entry), 64'd0);
    advance();

    // Concurrent read of slot 0 and write of slot 2, then invalidate mid-read
    idle(); EN_start_writing_prt_entry = 1'b1; EN_start_reading_prt_entry = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      idle(); EN_write_prt_entry = 1'b1; EN_read_prt_entry = 1'b1;
      write_prt_entry_data = 8'($urandom); tick();
    end
    idle(); EN_finish_writing_prt_entry = 1'b1; tick();
    idle(); EN_start_reading_prt_entry = 1'b1; tick();
    idle(); EN_read_prt_entry = 1'b1; tick();
    idle(); EN_read_prt_entry = 1'b1; EN_invalidate_prt_entry = 1'b1; tick();
    idle(); settle();
    chk("t5_rdy_read_off", 64'(RDY_read_prt_entry), 64'd0);
    chk("t5_slot0_free", 64'(RDY_invalidate_prt_entry), 64'd0);
    chk("t5_alloc0", 64'(start_writing_prt_entry), 64'd0);
    advance();

    // Reset during an active write and an active read
    idle(); EN_start_writing_prt_entry = 1'b1; EN_start_reading_prt_entry = 1'b1;
    start_reading_prt_entry_slot = 2'd2; tick();
    idle(); EN_write_prt_entry = 1'b1; EN_read_prt_entry = 1'b1; write_prt_entry_data = 8'h77; tick();
    idle(); invalidate_prt_entry_slot = 2'd1; start_reading_prt_entry_slot = 2'd1; settle();
    chk("t6_busy_w", 64'(RDY_abort_writing_prt_entry), 64'd1);
    chk("t6_busy_r", 64'(RDY_read_prt_entry), 64'd1);
    RST = 1'b1;
    #1;
    check_reset_literals("t6_async");
    m_reset();
    @(negedge CLK);
    tick();
    RST = 1'b0;
    idle(); EN_start_writing_prt_entry = 1'b1; settle();
    chk("t6_alloc0", 64'(start_writing_prt_entry), 64'd0);
    advance();

    // Random traffic
    for (int c = 0; c < 5000; c++) begin
      idle();
      EN_start_writing_prt_entry = ($urandom_range(0, 99) < 30);
      r = $urandom_range(0, 99);
      if (r < 60)      EN_write_prt_entry = 1'b1;
      else if (r < 70) EN_finish_writing_prt_entry = 1'b1;
      else if (r < 73) EN_abort_writing_prt_entry = 1'b1;
      write_prt_entry_data         = 8'($urandom);
      EN_start_reading_prt_entry   = ($urandom_range(0, 99) < 40);
      start_reading_prt_entry_slot = 2'($urandom_range(0, 3));
      EN_read_prt_entry            = ($urandom_range(0, 99) < 70);
      EN_invalidate_prt_entry      = ($urandom_range(0, 99) < 8);
      invalidate_prt_entry_slot    = 2'($urandom_range(0, 3));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
